// File: rtl/icache_pkg.sv
// Shared FSM encodings and address-field width helpers for the direct-mapped instruction cache.
package icache_pkg;

    localparam logic [2:0] ST_IDLE        = 3'd0;
    localparam logic [2:0] ST_LOOKUP      = 3'd1;
    localparam logic [2:0] ST_REFILL_REQ  = 3'd2;
    localparam logic [2:0] ST_REFILL_WAIT = 3'd3;
    localparam logic [2:0] ST_RESPOND     = 3'd4;

    function automatic int off_w(input int wpl);
        return $clog2(wpl);
    endfunction

    function automatic int idx_w(input int lines);
        return $clog2(lines);
    endfunction

    // The two low address bits select a byte within a word and are never stored.
    function automatic int tag_w(input int addr_w, input int lines, input int wpl);
        return addr_w - $clog2(lines) - $clog2(wpl) - 2;
    endfunction

endpackage

// File: rtl/icache_tag_array.sv
// Per-line tag and valid storage: valid bits reset/clear-all, one write/invalidate port, combinational hit compare.
module icache_tag_array
    import icache_pkg::*;
#(
    parameter int LINES = 16,
    parameter int TAG_W = 26
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_clr_all,
    input  logic                    i_inv,
    input  logic                    i_wr,
    input  logic [idx_w(LINES)-1:0] i_wr_idx,
    input  logic [TAG_W-1:0]        i_wr_tag,
    input  logic [idx_w(LINES)-1:0] i_rd_idx,
    input  logic [TAG_W-1:0]        i_rd_tag,
    output logic                    o_hit
);

    logic [LINES-1:0] r_valid;
    logic [TAG_W-1:0] r_tags [LINES];

    // Clear-all wins so a flush can never be undone by a coincident fill.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= '0;
        end else if (i_clr_all) begin
            r_valid <= '0;
        end else if (i_wr) begin
            r_valid[i_wr_idx] <= 1'b1;
        end else if (i_inv) begin
            r_valid[i_wr_idx] <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_wr) begin
            r_tags[i_wr_idx] <= i_wr_tag;
        end
    end

    assign o_hit = r_valid[i_rd_idx] && (r_tags[i_rd_idx] == i_rd_tag);

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache: hits answer one cycle after accept, misses refill the line word by word.
// One memory read outstanding at a time; no fetch-side backpressure on responses.
module icache_dm
    import icache_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LINES  = 16,
    parameter int WPL    = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_valid,
    input  logic [ADDR_W-1:0] i_req_addr,
    output logic              o_req_ready,
    output logic              o_resp_valid,
    output logic [DATA_W-1:0] o_resp_instr,
    input  logic              i_flush,
    output logic              o_mem_req_valid,
    output logic [ADDR_W-1:0] o_mem_req_addr,
    input  logic              i_mem_req_ready,
    input  logic              i_mem_resp_valid,
    input  logic [DATA_W-1:0] i_mem_resp_data
);

    localparam int OFF_W = off_w(WPL);
    localparam int IDX_W = idx_w(LINES);
    localparam int TAG_W = tag_w(ADDR_W, LINES, WPL);

    logic [2:0]        r_state;
    logic [TAG_W-1:0]  r_tag;
    logic [IDX_W-1:0]  r_idx;
    logic [OFF_W-1:0]  r_off;
    logic [OFF_W-1:0]  r_cnt;
    logic              r_flush_pend;
    logic [DATA_W-1:0] r_data [LINES*WPL];

    logic              w_hit;
    logic              w_accept;
    logic              w_mem_wr;
    logic              w_last;
    logic              w_to_idle;
    logic              w_clr_all;
    logic              w_inv;
    logic              w_tag_wr;
    logic [DATA_W-1:0] w_rd_word;
    logic              w_unused;

    assign w_unused = ^i_req_addr[1:0];

    assign o_req_ready = (r_state == ST_IDLE) && !i_rst;
    assign w_accept    = i_req_valid && o_req_ready;
    assign w_mem_wr    = (r_state == ST_REFILL_WAIT) && i_mem_resp_valid;
    assign w_last      = (r_cnt == OFF_W'(WPL - 1));
    assign w_tag_wr    = w_mem_wr && w_last;
    assign w_inv       = (r_state == ST_LOOKUP) && !w_hit;
    assign w_to_idle   = ((r_state == ST_LOOKUP) && w_hit) || (r_state == ST_RESPOND);

    // A flush seen while busy is deferred so the in-flight fetch still returns good data,
    // then it wipes every line, including the one just filled.
    assign w_clr_all = ((r_state == ST_IDLE) && i_flush)
                     || (w_to_idle && (r_flush_pend || i_flush));

    icache_tag_array #(
        .LINES (LINES),
        .TAG_W (TAG_W)
    ) u_tags (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clr_all (w_clr_all),
        .i_inv     (w_inv),
        .i_wr      (w_tag_wr),
        .i_wr_idx  (r_idx),
        .i_wr_tag  (r_tag),
        .i_rd_idx  (r_idx),
        .i_rd_tag  (r_tag),
        .o_hit     (w_hit)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_tag        <= '0;
            r_idx        <= '0;
            r_off        <= '0;
            r_cnt        <= '0;
            r_flush_pend <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_off   <= i_req_addr[OFF_W+1:2];
                        r_idx   <= i_req_addr[IDX_W+OFF_W+1:OFF_W+2];
                        r_tag   <= i_req_addr[ADDR_W-1:IDX_W+OFF_W+2];
                        r_state <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (w_hit) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt   <= '0;
                        r_state <= ST_REFILL_REQ;
                    end
                end
                ST_REFILL_REQ: begin
                    if (i_mem_req_ready) begin
                        r_state <= ST_REFILL_WAIT;
                    end
                end
                ST_REFILL_WAIT: begin
                    if (i_mem_resp_valid) begin
                        if (w_last) begin
                            r_state <= ST_RESPOND;
                        end else begin
                            r_cnt   <= r_cnt + 1'b1;
                            r_state <= ST_REFILL_REQ;
                        end
                    end
                end
                ST_RESPOND: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            if (w_to_idle) begin
                r_flush_pend <= 1'b0;
            end else if (i_flush && (r_state != ST_IDLE)) begin
                r_flush_pend <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_mem_wr) begin
            r_data[{r_idx, r_cnt}] <= i_mem_resp_data;
        end
    end

    // Asynchronous read: a word written at the previous edge is visible to LOOKUP/RESPOND.
    assign w_rd_word = r_data[{r_idx, r_off}];

    assign o_resp_valid    = ((r_state == ST_LOOKUP) && w_hit) || (r_state == ST_RESPOND);
    assign o_resp_instr    = o_resp_valid ? w_rd_word : '0;
    assign o_mem_req_valid = (r_state == ST_REFILL_REQ);
    assign o_mem_req_addr  = o_mem_req_valid ? {r_tag, r_idx, r_cnt, 2'b00} : '0;

endmodule

// File: tb/tb_icache_dm.sv
// Scoreboard bench for icache_dm: directed fetches against a stall/latency-configurable memory model.
module tb_icache_dm;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_req_valid = 1'b0;
    logic [31:0] i_req_addr = '0;
    logic        o_req_ready;
    logic        o_resp_valid;
    logic [31:0] o_resp_instr;
    logic        i_flush = 1'b0;
    logic        o_mem_req_valid;
    logic [31:0] o_mem_req_addr;
    logic        i_mem_req_ready = 1'b0;
    logic        i_mem_resp_valid = 1'b0;
    logic [31:0] i_mem_resp_data = '0;

    icache_dm #(.ADDR_W(32), .DATA_W(32), .LINES(16), .WPL(4)) dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_req_valid      (i_req_valid),
        .i_req_addr       (i_req_addr),
        .o_req_ready      (o_req_ready),
        .o_resp_valid     (o_resp_valid),
        .o_resp_instr     (o_resp_instr),
        .i_flush          (i_flush),
        .o_mem_req_valid  (o_mem_req_valid),
        .o_mem_req_addr   (o_mem_req_addr),
        .i_mem_req_ready  (i_mem_req_ready),
        .i_mem_resp_valid (i_mem_resp_valid),
        .i_mem_resp_data  (i_mem_resp_data)
    );

    always #5 i_clk = ~i_clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int n_resp   = 0;
    int resp_cyc = 0;
    int acc_cyc  = 0;
    int cfg_stall = 0;
    int cfg_lat   = 0;
    bit mdl_en    = 1'b1;
    logic [31:0] exp_q   [$];
    logic [31:0] mem_log [$];

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Response monitor: every response pulse must match the oldest expected instruction.
    initial begin
        forever begin
            @(negedge i_clk);
            if (!i_rst && o_resp_valid) begin
                n_resp++;
                resp_cyc = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_resp: got %h expected no response", o_resp_instr);
                end else begin
                    check("resp_instr", o_resp_instr, exp_q.pop_front());
                end
            end
        end
    end

    // Memory model: data = addr ^ A5A5_0000, cfg_stall ready-low cycles per request, cfg_lat wait cycles.
    initial begin
        bit          pend = 1'b0;
        bit          stalled = 1'b0;
        int          lat_left = 0;
        int          stall_left = 0;
        logic [31:0] paddr = '0;
        logic [31:0] saddr = '0;
        forever begin
            @(negedge i_clk);
            if (!mdl_en) begin
                pend = 1'b0;
                stalled = 1'b0;
                stall_left = cfg_stall;
                continue;
            end
            i_mem_resp_valid = 1'b0;
            i_mem_req_ready  = 1'b0;
            if (i_rst) begin
                pend = 1'b0;
                stalled = 1'b0;
                stall_left = cfg_stall;
                continue;
            end
            if (pend) begin
                if (lat_left == 0) begin
                    i_mem_resp_valid = 1'b1;
                    i_mem_resp_data  = paddr ^ 32'hA5A5_0000;
                    pend = 1'b0;
                end else begin
                    lat_left--;
                end
            end
            if (o_mem_req_valid && !pend) begin
                check("req_ready_low_in_refill", {31'd0, o_req_ready}, 32'd0);
                if (stalled) check("mem_addr_stable", o_mem_req_addr, saddr);
                if (stall_left > 0) begin
                    stall_left--;
                    stalled = 1'b1;
                    saddr = o_mem_req_addr;
                end else begin
                    i_mem_req_ready = 1'b1;
                    pend = 1'b1;
                    paddr = o_mem_req_addr;
                    lat_left = cfg_lat;
                    mem_log.push_back(o_mem_req_addr);
                    stall_left = cfg_stall;
                    stalled = 1'b0;
                end
            end else if (!o_mem_req_valid) begin
                stall_left = cfg_stall;
            end
        end
    end

    task automatic issue(input logic [31:0] a, input bit fl);
        int b = 0;
        @(negedge i_clk);
        i_req_valid = 1'b1;
        i_req_addr  = a;
        i_flush     = fl;
        while (!o_req_ready && b < 100) begin
            @(negedge i_clk);
            b++;
        end
        if (b >= 100) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: got req_ready=0 expected 1 for addr %h", a);
        end
        @(posedge i_clk);
        #1;
        acc_cyc     = cyc;
        i_req_valid = 1'b0;
        i_flush     = 1'b0;
    endtask

    task automatic do_req(input logic [31:0] a, input logic [31:0] exp_instr,
                          input logic [31:0] line_base, input bit exp_miss, input bit fl);
        int n0;
        int b = 0;
        mem_log.delete();
        exp_q.push_back(exp_instr);
        n0 = n_resp;
        issue(a, fl);
        while (n_resp == n0 && b < 300) begin
            @(negedge i_clk);
            #1;
            b++;
        end
        if (b >= 300) begin
            checks++;
            failures++;
            $display("FAIL resp_timeout: got no response expected %h", exp_instr);
            exp_q.delete();
        end
        if (exp_miss) begin
            check("miss_mem_req_count", mem_log.size(), 4);
            for (int i = 0; i < 4; i++) begin
                if (i < mem_log.size()) check("miss_mem_req_addr", mem_log[i], line_base + 32'(4 * i));
            end
        end else begin
            check("hit_mem_req_count", mem_log.size(), 0);
            check("hit_latency_cycles", resp_cyc - acc_cyc + 1, 1);
        end
    endtask

    initial begin
        int b;
        // Reset state.
        #3;
        check("rst_req_ready", {31'd0, o_req_ready}, 32'd0);
        check("rst_resp_valid", {31'd0, o_resp_valid}, 32'd0);
        check("rst_resp_instr", o_resp_instr, 32'd0);
        check("rst_mem_req_valid", {31'd0, o_mem_req_valid}, 32'd0);
        check("rst_mem_req_addr", o_mem_req_addr, 32'd0);
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        check("post_rst_req_ready", {31'd0, o_req_ready}, 32'd1);

        // 1 cold miss, 2 hit.
        do_req(32'h0000_0100, 32'hA5A5_0100, 32'h0000_0100, 1'b1, 1'b0);
        do_req(32'h0000_0108, 32'hA5A5_0108, 32'h0000_0100, 1'b0, 1'b0);
        do_req(32'h0000_0104, 32'hA5A5_0104, 32'h0000_0100, 1'b0, 1'b0);

        // 3 conflict on index 0.
        do_req(32'h0000_1100, 32'hA5A5_1100, 32'h0000_1100, 1'b1, 1'b0);
        do_req(32'h0000_110C, 32'hA5A5_110C, 32'h0000_1100, 1'b0, 1'b0);
        do_req(32'h0000_0100, 32'hA5A5_0100, 32'h0000_0100, 1'b1, 1'b0);

        // 4 memory backpressure and latency.
        cfg_stall = 5;
        cfg_lat   = 2;
        do_req(32'h0000_0204, 32'hA5A5_0204, 32'h0000_0200, 1'b1, 1'b0);
        cfg_stall = 0;
        cfg_lat   = 1;
        do_req(32'h0000_0A1C, 32'hA5A5_0A1C, 32'h0000_0A10, 1'b1, 1'b0);
        do_req(32'h0000_0A14, 32'hA5A5_0A14, 32'h0000_0A10, 1'b0, 1'b0);

        // 5 flush during word 2 of a refill.
        fork
            do_req(32'h0000_0308, 32'hA5A5_0308, 32'h0000_0300, 1'b1, 1'b0);
            begin
                b = 0;
                while (mem_log.size() < 3 && b < 200) begin
                    @(negedge i_clk);
                    #1;
                    b++;
                end
                @(negedge i_clk);
                i_flush = 1'b1;
                @(negedge i_clk);
                i_flush = 1'b0;
            end
        join
        do_req(32'h0000_0308, 32'hA5A5_0308, 32'h0000_0300, 1'b1, 1'b0);
        do_req(32'h0000_0A14, 32'hA5A5_0A14, 32'h0000_0A10, 1'b1, 1'b0);
        // Flush in IDLE together with a request that would otherwise hit.
        do_req(32'h0000_030C, 32'hA5A5_030C, 32'h0000_0300, 1'b1, 1'b1);

        // 6 asynchronous reset during REFILL_WAIT.
        cfg_lat = 3;
        mem_log.delete();
        issue(32'h0000_0414, 1'b0);
        b = 0;
        while (mem_log.size() < 2 && b < 200) begin
            @(negedge i_clk);
            #1;
            b++;
        end
        @(negedge i_clk);
        #2;
        mdl_en = 1'b0;
        i_mem_req_ready  = 1'b0;
        i_mem_resp_valid = 1'b0;
        i_rst = 1'b1;
        #1;
        check("midrst_req_ready", {31'd0, o_req_ready}, 32'd0);
        check("midrst_resp_valid", {31'd0, o_resp_valid}, 32'd0);
        check("midrst_resp_instr", o_resp_instr, 32'd0);
        check("midrst_mem_req_valid", {31'd0, o_mem_req_valid}, 32'd0);
        check("midrst_mem_req_addr", o_mem_req_addr, 32'd0);
        @(negedge i_clk);
        i_mem_resp_valid = 1'b1;
        i_mem_resp_data  = 32'hDEAD_BEEF;
        @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        i_mem_resp_valid = 1'b0;
        #1;
        check("after_stray_req_ready", {31'd0, o_req_ready}, 32'd1);
        check("after_stray_mem_req_valid", {31'd0, o_mem_req_valid}, 32'd0);
        mdl_en = 1'b1;
        do_req(32'h0000_030C, 32'hA5A5_030C, 32'h0000_0300, 1'b1, 1'b0);
        do_req(32'h0000_0414, 32'hA5A5_0414, 32'h0000_0410, 1'b1, 1'b0);
        do_req(32'h0000_0418, 32'hA5A5_0418, 32'h0000_0410, 1'b0, 1'b0);

        repeat (5) @(negedge i_clk);
        check("exp_q_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got simulation still running expected completion");
        $fatal(1);
    end

endmodule
